// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing / test-pattern generator:
// pattern mode encoding, default 720p60 timing and the colour-bar table.
package video_timing_pkg;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_GRAD  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    localparam int CNT_W = 12;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 220;
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FP     = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 20;

    // {R,G,B} on/off flags for bar index 0..7:
    // white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_flags(input logic [2:0] idx);
        return {~idx[1], ~idx[2], ~idx[0]};
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster counters with active-video, sync and
// frame-origin decode of the current counter state (combinational outputs).
module video_timing_counter
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             i_pixclk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             de,
    output logic             hsync_act,
    output logic             vsync_act,
    output logic             origin
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_size_check
            $fatal(1, "video_timing_counter: H_TOTAL and V_TOTAL must not exceed 4096");
        end
    endgenerate

    logic [CNT_W-1:0] h_reg, h_next;
    logic [CNT_W-1:0] v_reg, v_next;
    logic             run_reg;

    always_comb begin
        h_next = h_reg + CNT_W'(1);
        v_next = v_reg;
        if (h_reg == H_LAST) begin
            h_next = '0;
            v_next = (v_reg == V_LAST) ? '0 : v_reg + CNT_W'(1);
        end
    end

    // run_reg spends one cycle at (0,0) before counting so the first
    // visible pixel appears two edges after enable/reset release.
    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_reg   <= '0;
            v_reg   <= '0;
            run_reg <= 1'b0;
        end else if (!i_enable) begin
            h_reg   <= '0;
            v_reg   <= '0;
            run_reg <= 1'b0;
        end else if (!run_reg) begin
            run_reg <= 1'b1;
        end else begin
            h_reg <= h_next;
            v_reg <= v_next;
        end
    end

    assign h_cnt     = h_reg;
    assign v_cnt     = v_reg;
    assign de        = run_reg && (h_reg < H_ACT) && (v_reg < V_ACT);
    assign hsync_act = run_reg && (h_reg >= HS_START) && (h_reg <= HS_END);
    assign vsync_act = run_reg && (v_reg >= VS_START) && (v_reg <= VS_END);
    assign origin    = run_reg && (h_reg == '0) && (v_reg == '0);

endmodule

// File: rtl/video_timing_pattern_gen.sv
// Programmable video timing generator with frame-synchronous test-pattern
// selection; every output is registered one cycle after the counter state.
module video_timing_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CW       = 8,
    parameter int CHK_LOG2 = 5
) (
    input  logic            i_pixclk,
    input  logic            i_rst_n,
    input  logic            i_enable,
    input  logic [1:0]      i_mode,
    input  logic [3*CW-1:0] i_solid_rgb,
    output logic            o_hsync,
    output logic            o_vsync,
    output logic            o_de,
    output logic [3*CW-1:0] o_rgb,
    output logic [11:0]     o_x,
    output logic [11:0]     o_y,
    output logic            o_frame_start
);

    localparam logic HS_IDLE = ~HS_POL;
    localparam logic VS_IDLE = ~VS_POL;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             de;
    logic             hsync_act;
    logic             vsync_act;
    logic             origin;

    video_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_counter (
        .i_pixclk  (i_pixclk),
        .i_rst_n   (i_rst_n),
        .i_enable  (i_enable),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .de        (de),
        .hsync_act (hsync_act),
        .vsync_act (vsync_act),
        .origin    (origin)
    );

    mode_e           mode_reg;
    logic [3*CW-1:0] solid_reg;
    logic            capture;

    assign capture = i_enable && origin;

    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_reg  <= MODE_BARS;
            solid_reg <= '0;
        end else if (capture) begin
            mode_reg  <= mode_e'(i_mode);
            solid_reg <= i_solid_rgb;
        end
    end

    // Bar edges are elaboration-time constants; the bar index is the number
    // of edges the column has passed.
    logic [6:0] bar_ge;
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_bar_edge
            localparam int EDGE = ((gi + 1) * H_ACTIVE) / 8;
            assign bar_ge[gi] = (h_cnt >= CNT_W'(EDGE));
        end
    endgenerate

    logic [2:0]      bar_idx;
    logic [2:0]      bar_rgb;
    logic            chk_on;
    mode_e           mode_eff;
    logic [3*CW-1:0] solid_eff;
    logic [3*CW-1:0] rgb_next;

    // The origin pixel already uses the value being captured this edge.
    always_comb begin
        bar_idx = '0;
        for (int i = 0; i < 7; i++) begin
            bar_idx = bar_idx + {2'b00, bar_ge[i]};
        end
        bar_rgb   = bar_flags(bar_idx);
        chk_on    = h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2];
        mode_eff  = origin ? mode_e'(i_mode) : mode_reg;
        solid_eff = origin ? i_solid_rgb : solid_reg;
        rgb_next  = '0;
        case (mode_eff)
            MODE_BARS:  rgb_next = {{CW{bar_rgb[2]}}, {CW{bar_rgb[1]}}, {CW{bar_rgb[0]}}};
            MODE_SOLID: rgb_next = solid_eff;
            MODE_GRAD:  rgb_next = {3{CW'(h_cnt)}};
            MODE_CHECK: rgb_next = {(3*CW){chk_on}};
            default:    rgb_next = '0;
        endcase
        if (!de) begin
            rgb_next = '0;
        end
    end

    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_de          <= 1'b0;
            o_hsync       <= HS_IDLE;
            o_vsync       <= VS_IDLE;
            o_rgb         <= '0;
            o_x           <= '0;
            o_y           <= '0;
            o_frame_start <= 1'b0;
        end else if (!i_enable) begin
            o_de          <= 1'b0;
            o_hsync       <= HS_IDLE;
            o_vsync       <= VS_IDLE;
            o_rgb         <= '0;
            o_x           <= '0;
            o_y           <= '0;
            o_frame_start <= 1'b0;
        end else begin
            o_de          <= de;
            o_hsync       <= hsync_act ? HS_POL : HS_IDLE;
            o_vsync       <= vsync_act ? VS_POL : VS_IDLE;
            o_rgb         <= rgb_next;
            o_x           <= h_cnt;
            o_y           <= v_cnt;
            o_frame_start <= origin;
        end
    end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Directed bench: DUT A uses default 720p60 timing, DUT B a tiny raster
// (24x12, negative syncs, 4-pixel checker squares).
module tb_video_timing_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b;
    logic [1:0]  mode_a, mode_b;
    logic [23:0] solid_a, solid_b;

    logic        a_hsync, a_vsync, a_de, a_fs;
    logic [23:0] a_rgb;
    logic [11:0] a_x, a_y;
    logic        b_hsync, b_vsync, b_de, b_fs;
    logic [23:0] b_rgb;
    logic [11:0] b_x, b_y;

    int pass_cnt  = 0;
    int check_cnt = 0;

    int unsigned bar_pos [10] = '{0, 159, 160, 320, 480, 640, 800, 960, 1120, 1279};
    logic [23:0] bar_exp [10] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000, 24'h000000};

    always #5 clk = ~clk;

    video_timing_pattern_gen u_dut_a (
        .i_pixclk      (clk),
        .i_rst_n       (rst_n),
        .i_enable      (en_a),
        .i_mode        (mode_a),
        .i_solid_rgb   (solid_a),
        .o_hsync       (a_hsync),
        .o_vsync       (a_vsync),
        .o_de          (a_de),
        .o_rgb         (a_rgb),
        .o_x           (a_x),
        .o_y           (a_y),
        .o_frame_start (a_fs)
    );

    video_timing_pattern_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (2), .H_BP (4),
        .V_ACTIVE (8),  .V_FP (1), .V_SYNC (1), .V_BP (2),
        .HS_POL (1'b0), .VS_POL (1'b0), .CW (8), .CHK_LOG2 (2)
    ) u_dut_b (
        .i_pixclk      (clk),
        .i_rst_n       (rst_n),
        .i_enable      (en_b),
        .i_mode        (mode_b),
        .i_solid_rgb   (solid_b),
        .o_hsync       (b_hsync),
        .o_vsync       (b_vsync),
        .o_de          (b_de),
        .o_rgb         (b_rgb),
        .o_x           (b_x),
        .o_y           (b_y),
        .o_frame_start (b_fs)
    );

    // Leaves the bench on the negedge where pixel (0,0) is visible.
    task automatic restart_a();
        @(negedge clk); en_a = 1'b0;
        @(negedge clk); en_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic restart_b();
        @(negedge clk); en_b = 1'b0;
        @(negedge clk); en_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en_a = 1'b1; en_b = 1'b1;
        mode_a = 2'd0; mode_b = 2'd0; solid_a = '0; solid_b = '0;
        repeat (3) @(negedge clk);
        check_cnt++; if ({a_de, a_hsync, a_vsync, a_fs} !== 4'b0000) $display("FAIL reset_ctl_a: got %b expected 0000", {a_de, a_hsync, a_vsync, a_fs}); else pass_cnt++;
        check_cnt++; if (a_rgb !== 24'h0) $display("FAIL reset_rgb_a: got %h expected 000000", a_rgb); else pass_cnt++;
        check_cnt++; if ({b_hsync, b_vsync} !== 2'b11) $display("FAIL reset_sync_b: got %b expected 11", {b_hsync, b_vsync}); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        check_cnt++; if ({a_fs, a_de} !== 2'b00) $display("FAIL release_edge1: got fs/de %b expected 00", {a_fs, a_de}); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if ({a_fs, a_de} !== 2'b11) $display("FAIL release_edge2: got fs/de %b expected 11", {a_fs, a_de}); else pass_cnt++;
        check_cnt++; if ({a_x, a_y} !== 24'h0) $display("FAIL release_xy: got %0d,%0d expected 0,0", a_x, a_y); else pass_cnt++;
        check_cnt++; if (a_rgb !== 24'hFFFFFF) $display("FAIL release_rgb: got %h expected ffffff", a_rgb); else pass_cnt++;
        check_cnt++; if (b_fs !== 1'b1) $display("FAIL release_fs_b: got %b expected 1", b_fs); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if ({a_fs, a_x} !== {1'b0, 12'd1}) $display("FAIL release_next: got fs %b x %0d expected 0 1", a_fs, a_x); else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_line_timing();
        int de_cnt = 0, hs_cnt = 0, fs_cnt = 0, hs_first = -1, de_fall = -1;
        restart_a();
        for (int k = 0; k < 1650; k++) begin
            if (a_de) de_cnt++;
            if (!a_de && de_fall < 0) de_fall = k;
            if (a_hsync) begin hs_cnt++; if (hs_first < 0) hs_first = k; end
            if (a_fs) fs_cnt++;
            @(negedge clk);
        end
        check_cnt++; if (de_cnt !== 1280) $display("FAIL line_de_count: got %0d expected 1280", de_cnt); else pass_cnt++;
        check_cnt++; if (de_fall !== 1280) $display("FAIL line_de_fall: got %0d expected 1280", de_fall); else pass_cnt++;
        check_cnt++; if (hs_first !== 1390) $display("FAIL line_hs_start: got %0d expected 1390", hs_first); else pass_cnt++;
        check_cnt++; if (hs_cnt !== 40) $display("FAIL line_hs_width: got %0d expected 40", hs_cnt); else pass_cnt++;
        check_cnt++; if (fs_cnt !== 1) $display("FAIL line_fs_count: got %0d expected 1", fs_cnt); else pass_cnt++;
        check_cnt++; if ({a_de, a_fs, a_x, a_y} !== {2'b10, 12'd0, 12'd1}) $display("FAIL line_wrap: got de %b fs %b x %0d y %0d expected 1 0 0 1", a_de, a_fs, a_x, a_y); else pass_cnt++;
        $display("test_line_timing done: de %0d hs %0d at %0d", de_cnt, hs_cnt, hs_first);
    endtask

    task automatic test_bars();
        int j = 0;
        mode_a = 2'd0;
        restart_a();
        for (int k = 0; k < 1280; k++) begin
            if (j < 10 && k == int'(bar_pos[j])) begin
                check_cnt++;
                if (a_rgb !== bar_exp[j]) $display("FAIL bars_x%0d: got %h expected %h", k, a_rgb, bar_exp[j]); else pass_cnt++;
                j++;
            end
            @(negedge clk);
        end
        $display("test_bars done: %0d points", j);
    endtask

    task automatic test_small_timing();
        int de_cnt = 0, hs_low = 0, vs_low = 0, fs_cnt = 0;
        mode_b = 2'd0;
        restart_b();
        for (int k = 0; k < 288; k++) begin
            if (b_de) de_cnt++;
            if (!b_hsync) hs_low++;
            if (!b_vsync) vs_low++;
            if (b_fs) fs_cnt++;
            if (k == 17 || k == 18 || k == 19 || k == 20) begin
                check_cnt++; if (b_hsync !== (k == 17 || k == 20)) $display("FAIL small_hs_%0d: got %b expected %b", k, b_hsync, (k == 17 || k == 20)); else pass_cnt++;
            end
            if (k == 215 || k == 216 || k == 239 || k == 240) begin
                check_cnt++; if (b_vsync !== (k == 215 || k == 240)) $display("FAIL small_vs_%0d: got %b expected %b", k, b_vsync, (k == 215 || k == 240)); else pass_cnt++;
            end
            if (k == 24) begin
                check_cnt++; if ({b_de, b_x, b_y} !== {1'b1, 12'd0, 12'd1}) $display("FAIL small_line_period: got de %b x %0d y %0d expected 1 0 1", b_de, b_x, b_y); else pass_cnt++;
            end
            @(negedge clk);
        end
        check_cnt++; if (de_cnt !== 128) $display("FAIL small_de_count: got %0d expected 128", de_cnt); else pass_cnt++;
        check_cnt++; if (hs_low !== 24) $display("FAIL small_hs_low: got %0d expected 24", hs_low); else pass_cnt++;
        check_cnt++; if (vs_low !== 24) $display("FAIL small_vs_low: got %0d expected 24", vs_low); else pass_cnt++;
        check_cnt++; if (fs_cnt !== 1) $display("FAIL small_fs_count: got %0d expected 1", fs_cnt); else pass_cnt++;
        check_cnt++; if ({b_fs, b_de, b_x, b_y} !== {2'b11, 24'h0}) $display("FAIL small_frame_period: got fs %b de %b x %0d y %0d expected 1 1 0 0", b_fs, b_de, b_x, b_y); else pass_cnt++;
        $display("test_small_timing done: de %0d hs_low %0d vs_low %0d", de_cnt, hs_low, vs_low);
    endtask

    task automatic test_mode_switch();
        int bad = 0, blank_bad = 0, de_cnt = 0;
        mode_b = 2'd0; solid_b = 24'h0;
        restart_b();
        for (int k = 0; k < 576; k++) begin
            if (k == 60) begin
                check_cnt++; if (b_rgb !== 24'h0000FF) $display("FAIL switch_old_frame_60: got %h expected 0000ff", b_rgb); else pass_cnt++;
            end
            if (k == 171) begin
                check_cnt++; if (b_rgb !== 24'hFFFF00) $display("FAIL switch_old_frame_171: got %h expected ffff00", b_rgb); else pass_cnt++;
            end
            if (k >= 288) begin
                if (b_de) de_cnt++;
                if (b_de && b_rgb !== 24'h123456) bad++;
                if (!b_de && b_rgb !== 24'h0) blank_bad++;
            end
            if (k == 50) begin mode_b = 2'd1; solid_b = 24'h123456; end
            @(negedge clk);
        end
        check_cnt++; if (bad !== 0) $display("FAIL switch_solid_pixels: got %0d wrong expected 0", bad); else pass_cnt++;
        check_cnt++; if (blank_bad !== 0) $display("FAIL switch_blank_zero: got %0d nonzero expected 0", blank_bad); else pass_cnt++;
        check_cnt++; if (de_cnt !== 128) $display("FAIL switch_de_count: got %0d expected 128", de_cnt); else pass_cnt++;
        $display("test_mode_switch done: %0d wrong solid pixels", bad);
    endtask

    task automatic test_same_edge_capture();
        mode_b = 2'd1; solid_b = 24'h123456;
        restart_b();
        check_cnt++; if (b_rgb !== 24'h123456) $display("FAIL capture_restart: got %h expected 123456", b_rgb); else pass_cnt++;
        repeat (287) @(negedge clk);
        mode_b = 2'd2;
        @(negedge clk);
        check_cnt++; if ({b_fs, b_rgb} !== {1'b1, 24'h000000}) $display("FAIL capture_origin: got fs %b rgb %h expected 1 000000", b_fs, b_rgb); else pass_cnt++;
        repeat (5) @(negedge clk);
        check_cnt++; if (b_rgb !== 24'h050505) $display("FAIL grad_x5: got %h expected 050505", b_rgb); else pass_cnt++;
        mode_b = 2'd3;
        repeat (28) @(negedge clk);
        check_cnt++; if (b_rgb !== 24'h090909) $display("FAIL grad_hold_midframe: got %h expected 090909", b_rgb); else pass_cnt++;
        repeat (255) @(negedge clk);
        check_cnt++; if (b_fs !== 1'b1) $display("FAIL checker_frame_start: got %b expected 1", b_fs); else pass_cnt++;
        for (int k = 0; k <= 125; k++) begin
            if (k == 4) begin
                check_cnt++; if (b_rgb !== 24'hFFFFFF) $display("FAIL checker_4_0: got %h expected ffffff", b_rgb); else pass_cnt++;
            end
            if (k == 97) begin
                check_cnt++; if (b_rgb !== 24'hFFFFFF) $display("FAIL checker_1_4: got %h expected ffffff", b_rgb); else pass_cnt++;
            end
            if (k == 125) begin
                check_cnt++; if (b_rgb !== 24'h000000) $display("FAIL checker_5_5: got %h expected 000000", b_rgb); else pass_cnt++;
            end
            if (k < 125) @(negedge clk);
        end
        $display("test_same_edge_capture done");
    endtask

    task automatic test_enable_drop();
        mode_a = 2'd0;
        restart_a();
        repeat (100) @(negedge clk);
        check_cnt++; if ({a_de, a_x} !== {1'b1, 12'd100}) $display("FAIL enable_pre: got de %b x %0d expected 1 100", a_de, a_x); else pass_cnt++;
        en_a = 1'b0;
        @(negedge clk);
        check_cnt++; if ({a_de, a_hsync, a_x, a_rgb} !== 38'h0) $display("FAIL enable_idle: got de %b hs %b x %0d rgb %h expected all 0", a_de, a_hsync, a_x, a_rgb); else pass_cnt++;
        repeat (3) @(negedge clk);
        en_a = 1'b1;
        @(negedge clk);
        check_cnt++; if ({a_de, a_fs} !== 2'b00) $display("FAIL enable_rise_edge1: got de/fs %b expected 00", {a_de, a_fs}); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if ({a_de, a_fs, a_x, a_y} !== {2'b11, 24'h0}) $display("FAIL enable_restart: got de %b fs %b x %0d y %0d expected 1 1 0 0", a_de, a_fs, a_x, a_y); else pass_cnt++;
        $display("test_enable_drop done");
    endtask

    task automatic test_reset_midline();
        restart_a();
        repeat (200) @(negedge clk);
        check_cnt++; if ({a_de, a_x} !== {1'b1, 12'd200}) $display("FAIL rst_mid_pre: got de %b x %0d expected 1 200", a_de, a_x); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        check_cnt++; if ({a_de, a_hsync, a_x, a_rgb} !== 38'h0) $display("FAIL rst_mid_async: got de %b hs %b x %0d rgb %h expected all 0", a_de, a_hsync, a_x, a_rgb); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_cnt++; if (a_fs !== 1'b0) $display("FAIL rst_mid_edge1: got fs %b expected 0", a_fs); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if ({a_fs, a_de, a_x, a_y} !== {2'b11, 24'h0}) $display("FAIL rst_mid_restart: got fs %b de %b x %0d y %0d expected 1 1 0 0", a_fs, a_de, a_x, a_y); else pass_cnt++;
        $display("test_reset_midline done");
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_bars();
        test_small_timing();
        test_mode_switch();
        test_same_edge_capture();
        test_enable_drop();
        test_reset_midline();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
